// File: rtl/bnn_pkg.sv
// Shared constants and FSM state encoding for the binary FC layer datapath.
package bnn_pkg;

   localparam int BNN_IN_BITS   = 784;
   localparam int BNN_N_NEURONS = 256;
   localparam int BNN_ADDR_W    = $clog2(BNN_N_NEURONS);
   localparam int BNN_TH_W      = 10;
   localparam int BNN_MEM_LAT   = 1;
   localparam int BNN_TIMEOUT   = 64;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_WAIT_MEM = 3'd2,
      ST_ISSUE    = 3'd3,
      ST_WAIT_RES = 3'd4,
      ST_DONE     = 3'd5
   } seq_state_t;

endpackage

// File: rtl/fc_layer_sequencer_if.sv
// Weight-memory read port and neuron request/response channel, named from the sequencer's side.
interface fc_layer_sequencer_if
   import bnn_pkg::*;
#(
   parameter int IN_BITS = BNN_IN_BITS,
   parameter int ADDR_W  = BNN_ADDR_W,
   parameter int TH_W    = BNN_TH_W
);

   logic               o_w_rd_en;
   logic [ADDR_W-1:0]  o_w_addr;
   logic [IN_BITS-1:0] i_w_rdata;
   logic [TH_W-1:0]    i_th_rdata;
   logic               o_nrn_valid;
   logic [IN_BITS-1:0] o_nrn_data;
   logic [IN_BITS-1:0] o_nrn_weight;
   logic [TH_W-1:0]    o_nrn_threshold;
   logic               i_nrn_result;
   logic               i_nrn_valid;

   modport master (
      output o_w_rd_en, o_w_addr, o_nrn_valid, o_nrn_data, o_nrn_weight, o_nrn_threshold,
      input  i_w_rdata, i_th_rdata, i_nrn_result, i_nrn_valid
   );

   modport slave (
      input  o_w_rd_en, o_w_addr, o_nrn_valid, o_nrn_data, o_nrn_weight, o_nrn_threshold,
      output i_w_rdata, i_th_rdata, i_nrn_result, i_nrn_valid
   );

endinterface

// File: rtl/bnn_result_collector.sv
// Layer output vector: one bit written per returned neuron result, cleared on a new layer.
module bnn_result_collector
   import bnn_pkg::*;
#(
   parameter int N_NEURONS = BNN_N_NEURONS,
   parameter int ADDR_W    = BNN_ADDR_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 wr_en,
   input  logic [ADDR_W-1:0]    wr_idx,
   input  logic                 wr_bit,
   output logic [N_NEURONS-1:0] layer_out
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         layer_out <= '0;
      end else if (clr) begin
         layer_out <= '0;
      end else if (wr_en) begin
         layer_out[wr_idx] <= wr_bit;
      end
   end

endmodule

// File: rtl/fc_layer_sequencer.sv
// Layer sequencer: fetches each neuron's weight row and threshold, issues one neuron request
// at a time and gathers the returned bits into the layer output vector.
//
// state    | meaning
// IDLE     | waiting for i_start; image latched on accept
// FETCH    | weight/threshold read strobe for neuron idx
// WAIT_MEM | counting down memory latency, capture rdata on terminal count
// ISSUE    | single-cycle request strobe to the neuron
// WAIT_RES | one request in flight; result or timeout ends it
// DONE     | one-cycle completion pulse, busy drops on exit
module fc_layer_sequencer
   import bnn_pkg::*;
#(
   parameter int IN_BITS   = BNN_IN_BITS,
   parameter int N_NEURONS = BNN_N_NEURONS,
   parameter int ADDR_W    = BNN_ADDR_W,
   parameter int TH_W      = BNN_TH_W,
   parameter int MEM_LAT   = BNN_MEM_LAT,
   parameter int TIMEOUT   = BNN_TIMEOUT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_start,
   input  logic [IN_BITS-1:0]   i_image,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_err,
   output logic [N_NEURONS-1:0] o_layer_out,
   fc_layer_sequencer_if.master bus
);

   localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(MEM_LAT - 1);
   localparam logic [TMO_W-1:0]  TMO_LOAD = TMO_W'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(N_NEURONS - 1);

   seq_state_t        state, state_d;
   logic [ADDR_W-1:0] idx, idx_d;
   logic [LAT_W-1:0]  lat_cnt, lat_d;
   logic [TMO_W-1:0]  tmo_cnt, tmo_d;
   logic              rd_en_d, nrn_valid_d, done_d, busy_d, err_d;
   logic              latch_img, latch_w, clr_res, res_we;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d     = state;
      idx_d       = idx;
      lat_d       = lat_cnt;
      tmo_d       = tmo_cnt;
      rd_en_d     = 1'b0;
      nrn_valid_d = 1'b0;
      done_d      = 1'b0;
      busy_d      = o_busy;
      err_d       = o_err;
      latch_img   = 1'b0;
      latch_w     = 1'b0;
      clr_res     = 1'b0;
      res_we      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_start) begin
               latch_img = 1'b1;
               clr_res   = 1'b1;
               err_d     = 1'b0;
               busy_d    = 1'b1;
               idx_d     = '0;
               rd_en_d   = 1'b1;
               state_d   = ST_FETCH;
            end
         end
         ST_FETCH: begin
            lat_d   = LAT_LOAD;
            state_d = ST_WAIT_MEM;
         end
         ST_WAIT_MEM: begin
            if (lat_cnt == '0) begin
               latch_w     = 1'b1;
               nrn_valid_d = 1'b1;
               tmo_d       = TMO_LOAD;
               state_d     = ST_ISSUE;
            end else begin
               lat_d = lat_cnt - LAT_W'(1);
            end
         end
         ST_ISSUE: begin
            tmo_d   = tmo_cnt - TMO_W'(1);
            state_d = ST_WAIT_RES;
         end
         ST_WAIT_RES: begin
            if (bus.i_nrn_valid) begin
               res_we = 1'b1;
               // terminal check before increment keeps idx from wrapping
               if (idx == IDX_LAST) begin
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx + ADDR_W'(1);
                  rd_en_d = 1'b1;
                  state_d = ST_FETCH;
               end
            end else if (tmo_cnt == '0) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               tmo_d = tmo_cnt - TMO_W'(1);
            end
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // a result strobe outside WAIT_RES has no request to belong to
      if (bus.i_nrn_valid && (state != ST_WAIT_RES)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx                 <= '0;
         lat_cnt             <= '0;
         tmo_cnt             <= '0;
         o_busy              <= 1'b0;
         o_done              <= 1'b0;
         o_err               <= 1'b0;
         bus.o_w_rd_en       <= 1'b0;
         bus.o_w_addr        <= '0;
         bus.o_nrn_valid     <= 1'b0;
         bus.o_nrn_data      <= '0;
         bus.o_nrn_weight    <= '0;
         bus.o_nrn_threshold <= '0;
      end else begin
         idx             <= idx_d;
         lat_cnt         <= lat_d;
         tmo_cnt         <= tmo_d;
         o_busy          <= busy_d;
         o_done          <= done_d;
         o_err           <= err_d;
         bus.o_w_rd_en   <= rd_en_d;
         bus.o_nrn_valid <= nrn_valid_d;
         if (rd_en_d) begin
            bus.o_w_addr <= idx_d;
         end
         if (latch_img) begin
            bus.o_nrn_data <= i_image;
         end
         if (latch_w) begin
            bus.o_nrn_weight    <= bus.i_w_rdata;
            bus.o_nrn_threshold <= bus.i_th_rdata;
         end
      end
   end

   bnn_result_collector #(
      .N_NEURONS (N_NEURONS),
      .ADDR_W    (ADDR_W)
   ) u_collector (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr_res),
      .wr_en     (res_we),
      .wr_idx    (idx),
      .wr_bit    (bus.i_nrn_result),
      .layer_out (o_layer_out)
   );

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed bench: two sequencers (MEM_LAT 1 and 3) driven in lockstep, each with its own
// weight-memory and fixed-latency neuron model.
module tb_fc_layer_sequencer;

   localparam int IN_BITS = 16;
   localparam int NN      = 4;
   localparam int AW      = 2;
   localparam int TH_W    = 10;
   localparam int TMO     = 64;
   localparam int L       = 14;

   localparam logic [15:0] ROWS [4] = '{16'h1E2D, 16'hB40F, 16'h6A91, 16'hC35C};
   localparam logic [9:0]  THS  [4] = '{10'd100, 10'd7, 10'd513, 10'd999};
   localparam logic [15:0] GARB    = 16'hDEAD;
   localparam logic [9:0]  GARB_TH = 10'h3FF;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic spur = 1'b0;
   logic [IN_BITS-1:0] image = '0;
   logic [3:0] res_v = 4'b1101;
   int drop_k = -1;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   logic               busy_a [2], done_a [2], err_a [2], rd_en_a [2], nvo_a [2], nvi_a [2], res_a [2];
   logic [NN-1:0]      lo_a [2];
   logic [AW-1:0]      addr_a [2];
   logic [IN_BITS-1:0] wdat_a [2], nw_a [2], nd_a [2];
   logic [TH_W-1:0]    th_a [2], nth_a [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      fc_layer_sequencer_if #(.IN_BITS(IN_BITS), .ADDR_W(AW), .TH_W(TH_W)) bus ();

      fc_layer_sequencer #(
         .IN_BITS   (IN_BITS),
         .N_NEURONS (NN),
         .ADDR_W    (AW),
         .TH_W      (TH_W),
         .MEM_LAT   ((g == 0) ? 1 : 3),
         .TIMEOUT   (TMO)
      ) dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .i_start     (start),
         .i_image     (image),
         .o_busy      (busy_a[g]),
         .o_done      (done_a[g]),
         .o_err       (err_a[g]),
         .o_layer_out (lo_a[g]),
         .bus         (bus)
      );

      assign rd_en_a[g]         = bus.o_w_rd_en;
      assign addr_a[g]          = bus.o_w_addr;
      assign nvo_a[g]           = bus.o_nrn_valid;
      assign nd_a[g]            = bus.o_nrn_data;
      assign nw_a[g]            = bus.o_nrn_weight;
      assign nth_a[g]           = bus.o_nrn_threshold;
      assign bus.i_w_rdata      = wdat_a[g];
      assign bus.i_th_rdata     = th_a[g];
      assign bus.i_nrn_result   = res_a[g];
      assign bus.i_nrn_valid    = nvi_a[g] | spur;
   end

   // model state and per-run observation records
   int         mrem [2], nrem [2], nreq [2], start_cyc [2];
   logic [1:0] maddr [2], ncur [2];
   int         n_fetch [2], n_strobe [2], n_done [2], done_cyc [2];
   int         fetch_addr [2][8], strobe_cyc [2][8];
   logic [15:0] strobe_w [2][8], strobe_d [2][8];
   logic [9:0]  strobe_th [2][8];

   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (!rst_n) begin
            mrem[g] = 0; nrem[g] = 0; nreq[g] = 0;
            nvi_a[g] = 1'b0; res_a[g] = 1'b0;
            wdat_a[g] = GARB; th_a[g] = GARB_TH;
         end else begin
            if (start && !busy_a[g]) begin
               start_cyc[g] = cyc;
               n_fetch[g] = 0; n_strobe[g] = 0; n_done[g] = 0; done_cyc[g] = -1;
               mrem[g] = 0; nrem[g] = 0; nreq[g] = 0;
            end
            wdat_a[g] = GARB; th_a[g] = GARB_TH;
            if (mrem[g] > 0) begin
               mrem[g]--;
               if (mrem[g] == 0) begin
                  wdat_a[g] = ROWS[maddr[g]];
                  th_a[g]   = THS[maddr[g]];
               end
            end
            if (rd_en_a[g]) begin
               mrem[g]  = (g == 0) ? 1 : 3;
               maddr[g] = addr_a[g];
               if (n_fetch[g] < 8) fetch_addr[g][n_fetch[g]] = int'(addr_a[g]);
               n_fetch[g]++;
            end
            nvi_a[g] = 1'b0; res_a[g] = 1'b0;
            if (nrem[g] > 0) begin
               nrem[g]--;
               if (nrem[g] == 0 && int'(ncur[g]) != drop_k) begin
                  nvi_a[g] = 1'b1;
                  res_a[g] = res_v[ncur[g]];
               end
            end
            if (nvo_a[g]) begin
               ncur[g] = nreq[g][1:0];
               nreq[g]++;
               nrem[g] = L;
               if (n_strobe[g] < 8) begin
                  strobe_cyc[g][n_strobe[g]] = cyc - start_cyc[g];
                  strobe_w[g][n_strobe[g]]   = nw_a[g];
                  strobe_th[g][n_strobe[g]]  = nth_a[g];
                  strobe_d[g][n_strobe[g]]   = nd_a[g];
               end
               n_strobe[g]++;
            end
            if (done_a[g]) begin
               n_done[g]++;
               done_cyc[g] = cyc - start_cyc[g];
            end
         end
      end
   end

   task automatic run_layer(input logic [IN_BITS-1:0] img, input int wait_cycles);
      @(posedge clk); #1;
      image = img;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (wait_cycles) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         vectors++;
         if ({busy_a[g], done_a[g], err_a[g], rd_en_a[g], nvo_a[g]} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl[%0d]: got %b want 00000", g, {busy_a[g], done_a[g], err_a[g], rd_en_a[g], nvo_a[g]});
         end
         vectors++;
         if ({lo_a[g], addr_a[g], nd_a[g], nw_a[g], nth_a[g]} !== '0) begin
            errors++; $display("FAIL reset_data[%0d]: layer %b addr %0d data %h w %h th %0d, want all 0", g, lo_a[g], addr_a[g], nd_a[g], nw_a[g], nth_a[g]);
         end
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      run_layer(16'hA55A, 90);
      vectors++;
      if (lo_a[0] !== 4'b1101) begin errors++; $display("FAIL basic_layer: got %b want 1101", lo_a[0]); end
      vectors++;
      if (n_done[0] !== 1 || done_cyc[0] !== 69) begin
         errors++; $display("FAIL basic_done: pulses %0d at cycle %0d, want 1 at 69", n_done[0], done_cyc[0]);
      end
      vectors++;
      if ({err_a[0], busy_a[0]} !== 2'b00) begin errors++; $display("FAIL basic_err_busy: got %b want 00", {err_a[0], busy_a[0]}); end
      vectors++;
      if (n_fetch[0] !== 4) begin errors++; $display("FAIL basic_nfetch: got %0d want 4", n_fetch[0]); end
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (fetch_addr[0][k] !== k) begin errors++; $display("FAIL basic_addr[%0d]: got %0d want %0d", k, fetch_addr[0][k], k); end
         vectors++;
         if (strobe_cyc[0][k] !== 3 + 17 * k) begin
            errors++; $display("FAIL basic_strobe_cyc[%0d]: got %0d want %0d", k, strobe_cyc[0][k], 3 + 17 * k);
         end
         vectors++;
         if ({strobe_w[0][k], strobe_th[0][k], strobe_d[0][k]} !== {ROWS[k], THS[k], 16'hA55A}) begin
            errors++; $display("FAIL basic_req[%0d]: w %h th %0d data %h, want %h %0d a55a", k, strobe_w[0][k], strobe_th[0][k], strobe_d[0][k], ROWS[k], THS[k]);
         end
      end
   endtask

   task automatic test_mem_lat3();
      run_layer(16'h0FF0, 100);
      vectors++;
      if (lo_a[1] !== 4'b1101 || err_a[1] !== 1'b0) begin
         errors++; $display("FAIL lat3_layer: got %b err %b want 1101 err 0", lo_a[1], err_a[1]);
      end
      vectors++;
      if (n_done[1] !== 1 || done_cyc[1] !== 77) begin
         errors++; $display("FAIL lat3_done: pulses %0d at cycle %0d, want 1 at 77", n_done[1], done_cyc[1]);
      end
      vectors++;
      if (n_strobe[1] !== 4) begin errors++; $display("FAIL lat3_nstrobe: got %0d want 4", n_strobe[1]); end
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (strobe_cyc[1][k] !== 5 + 19 * k) begin
            errors++; $display("FAIL lat3_strobe_cyc[%0d]: got %0d want %0d", k, strobe_cyc[1][k], 5 + 19 * k);
         end
         vectors++;
         if ({strobe_w[1][k], strobe_th[1][k], strobe_d[1][k]} !== {ROWS[k], THS[k], 16'h0FF0}) begin
            errors++; $display("FAIL lat3_req[%0d]: w %h th %0d data %h, want %h %0d 0ff0", k, strobe_w[1][k], strobe_th[1][k], strobe_d[1][k], ROWS[k], THS[k]);
         end
      end
   endtask

   task automatic test_restart_busy();
      @(posedge clk); #1;
      image = 16'h1234;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      image = 16'hFFFF;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (80) @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
         vectors++;
         if (lo_a[g] !== 4'b1101 || err_a[g] !== 1'b0) begin
            errors++; $display("FAIL restart_layer[%0d]: got %b err %b want 1101 err 0", g, lo_a[g], err_a[g]);
         end
         vectors++;
         if (n_done[g] !== 1 || done_cyc[g] !== ((g == 0) ? 69 : 77)) begin
            errors++; $display("FAIL restart_done[%0d]: pulses %0d at cycle %0d, want 1 at %0d", g, n_done[g], done_cyc[g], (g == 0) ? 69 : 77);
         end
         vectors++;
         if (strobe_d[g][3] !== 16'h1234) begin errors++; $display("FAIL restart_image[%0d]: got %h want 1234", g, strobe_d[g][3]); end
      end
   endtask

   task automatic test_timeout();
      drop_k = 2;
      run_layer(16'h5A5A, 120);
      for (int g = 0; g < 2; g++) begin
         vectors++;
         if (err_a[g] !== 1'b1) begin errors++; $display("FAIL tmo_err[%0d]: got %b want 1", g, err_a[g]); end
         vectors++;
         if (n_done[g] !== 1 || done_cyc[g] !== ((g == 0) ? 101 : 107)) begin
            errors++; $display("FAIL tmo_done[%0d]: pulses %0d at cycle %0d, want 1 at %0d", g, n_done[g], done_cyc[g], (g == 0) ? 101 : 107);
         end
         vectors++;
         if (lo_a[g] !== 4'b0001) begin errors++; $display("FAIL tmo_layer[%0d]: got %b want 0001", g, lo_a[g]); end
         vectors++;
         if (n_strobe[g] !== 3 || busy_a[g] !== 1'b0) begin
            errors++; $display("FAIL tmo_strobes[%0d]: strobes %0d busy %b want 3 busy 0", g, n_strobe[g], busy_a[g]);
         end
      end
      drop_k = -1;
   endtask

   task automatic test_reset_midlayer();
      run_layer(16'h00FF, 24);
      #3;
      rst_n = 1'b0;
      #1;
      for (int g = 0; g < 2; g++) begin
         vectors++;
         if ({busy_a[g], done_a[g], err_a[g], rd_en_a[g], nvo_a[g], lo_a[g], addr_a[g], nd_a[g], nw_a[g], nth_a[g]} !== '0) begin
            errors++; $display("FAIL midreset_outputs[%0d]: busy %b layer %b addr %0d data %h w %h th %0d, want all 0", g, busy_a[g], lo_a[g], addr_a[g], nd_a[g], nw_a[g], nth_a[g]);
         end
      end
      repeat (5) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         vectors++;
         if (n_done[g] !== 0) begin errors++; $display("FAIL midreset_nodone[%0d]: got %0d pulses want 0", g, n_done[g]); end
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_layer(16'hC0DE, 90);
      for (int g = 0; g < 2; g++) begin
         vectors++;
         if (lo_a[g] !== 4'b1101 || err_a[g] !== 1'b0 || n_done[g] !== 1 || done_cyc[g] !== ((g == 0) ? 69 : 77)) begin
            errors++; $display("FAIL midreset_rerun[%0d]: layer %b err %b pulses %0d at %0d, want 1101 0 1 at %0d", g, lo_a[g], err_a[g], n_done[g], done_cyc[g], (g == 0) ? 69 : 77);
         end
      end
   endtask

   task automatic test_spurious();
      @(posedge clk); #1;
      spur = 1'b1;
      @(posedge clk); #1;
      spur = 1'b0;
      @(posedge clk); #1;
      for (int g = 0; g < 2; g++) begin
         vectors++;
         if (err_a[g] !== 1'b1) begin errors++; $display("FAIL spur_err[%0d]: got %b want 1", g, err_a[g]); end
         vectors++;
         if (lo_a[g] !== 4'b1101 || busy_a[g] !== 1'b0) begin
            errors++; $display("FAIL spur_hold[%0d]: layer %b busy %b want 1101 0", g, lo_a[g], busy_a[g]);
         end
      end
      run_layer(16'h7777, 1);
      for (int g = 0; g < 2; g++) begin
         vectors++;
         if (err_a[g] !== 1'b0 || lo_a[g] !== 4'b0000) begin
            errors++; $display("FAIL spur_clear[%0d]: err %b layer %b want 0 0000", g, err_a[g], lo_a[g]);
         end
      end
      repeat (90) @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
         vectors++;
         if (lo_a[g] !== 4'b1101 || err_a[g] !== 1'b0 || n_done[g] !== 1) begin
            errors++; $display("FAIL spur_rerun[%0d]: layer %b err %b pulses %0d want 1101 0 1", g, lo_a[g], err_a[g], n_done[g]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_mem_lat3();
      test_restart_busy();
      test_timeout();
      test_reset_midlayer();
      test_spurious();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
